// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 scan event decoder and its event FIFO.
//   PS2_PREFIX_EXT / PS2_PREFIX_BRK : E0 (extended) and F0 (break) prefix bytes
//   ps2_state_e                     : decoder FSM state encoding (2 bits)
//   EV_W and EV_*_BIT/MSB/LSB       : event word layout {ext, brk, code[7:0]}
//   ps2_pack_event()                : builds an event word from its fields
package ps2_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StPreE0   = 2'd1,
      StPreF0   = 2'd2,
      StPreE0F0 = 2'd3
   } ps2_state_e;

   localparam int unsigned EV_W        = 10;
   localparam int unsigned EV_EXT_BIT  = 9;
   localparam int unsigned EV_BRK_BIT  = 8;
   localparam int unsigned EV_CODE_MSB = 7;
   localparam int unsigned EV_CODE_LSB = 0;

   function automatic logic [EV_W-1:0] ps2_pack_event(input logic       ext,
                                                      input logic       brk,
                                                      input logic [7:0] code);
      logic [EV_W-1:0] ev;
      ev                          = '0;
      ev[EV_EXT_BIT]              = ext;
      ev[EV_BRK_BIT]              = brk;
      ev[EV_CODE_MSB:EV_CODE_LSB] = code;
      return ev;
   endfunction

endpackage

// File: rtl/ps2_scan_event_decoder_if.sv
// ps2_scan_event_decoder_if: byte-receiver input and event-consumer output of the decoder.
//   rx_ready/rx_data         : byte strobe and byte from the PS/2 receiver
//   ev_pop/clr_overflow      : consumer pop and overflow clear
//   ev_valid/ev_code/ev_ext/ev_break/ev_count : show-ahead head event and fill level
//   overflow/proto_err       : sticky drop flag and one-cycle protocol error pulse
// master = receiver/consumer side, slave = decoder side.
// FIFO_DEPTH must match the FIFO_DEPTH of the decoder the interface is attached to.
interface ps2_scan_event_decoder_if #(
   parameter int unsigned FIFO_DEPTH = 8
) ();

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             rx_ready;
   logic [7:0]       rx_data;
   logic             ev_pop;
   logic             clr_overflow;
   logic             ev_valid;
   logic [7:0]       ev_code;
   logic             ev_ext;
   logic             ev_break;
   logic [CNT_W-1:0] ev_count;
   logic             overflow;
   logic             proto_err;

   modport master (
      output rx_ready, rx_data, ev_pop, clr_overflow,
      input  ev_valid, ev_code, ev_ext, ev_break, ev_count, overflow, proto_err
   );

   modport slave (
      input  rx_ready, rx_data, ev_pop, clr_overflow,
      output ev_valid, ev_code, ev_ext, ev_break, ev_count, overflow, proto_err
   );

endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous show-ahead FIFO for decoded key events.
//   clk, reset : clock, asynchronous active-high reset
//   i_push     : write i_data; dropped when full unless i_pop frees a slot this cycle
//   i_pop      : remove head entry; ignored when empty
//   o_data     : head entry (zero while empty)
//   o_empty, o_full, o_count : fill status, o_count ranges 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = EV_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_empty,
   output logic                   o_full,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   assign o_count = r_count;
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

   // A pop on a full FIFO frees the slot the simultaneous push lands in.
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push_ok && !w_pop_ok) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop_ok && !w_push_ok) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/ps2_scan_event_decoder.sv
// ps2_scan_event_decoder: turns the PS/2 byte stream into key events {ext, brk, code}.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of ps2_scan_event_decoder_if
//                (rx byte strobe in, show-ahead event FIFO head, overflow, proto_err out)
// E0 marks an extended key, F0 a release. Partial prefixes are abandoned after
// TIMEOUT_CYCLES-1 byte-less cycles. REPORT_MAKE=0 suppresses make events.
module ps2_scan_event_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
   parameter int unsigned REPORT_MAKE    = 1
) (
   input logic                     clk,
   input logic                     reset,
   ps2_scan_event_decoder_if.slave bus
);

   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   // Timeout fires on the edge that would take the counter to TIMEOUT_CYCLES-1.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
   localparam logic MAKE_EN = (REPORT_MAKE != 0);

   ps2_state_e       r_state;
   ps2_state_e       w_state_next;
   logic [TO_W-1:0]  r_to_cnt;
   logic [TO_W-1:0]  w_to_cnt_next;
   logic             w_is_ext;
   logic             w_is_brk;
   logic             w_timeout;
   logic             w_emit;
   logic             w_emit_ext;
   logic             w_emit_brk;
   logic             w_err;
   logic             r_proto_err;
   logic             r_overflow;
   logic [EV_W-1:0]  w_head;
   logic             w_empty;
   logic             w_full;
   logic [CNT_W-1:0] w_count;

   assign w_is_ext  = (bus.rx_data == PS2_PREFIX_EXT);
   assign w_is_brk  = (bus.rx_data == PS2_PREFIX_BRK);
   // A byte arriving on the timeout cycle takes priority over the timeout.
   assign w_timeout = (r_state != StIdle) && !bus.rx_ready && (r_to_cnt == TO_LAST);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      if (bus.rx_ready) begin
         case (r_state)
            StIdle: begin
               if (w_is_ext)      w_state_next = StPreE0;
               else if (w_is_brk) w_state_next = StPreF0;
            end
            StPreE0: begin
               if (w_is_brk)      w_state_next = StPreE0F0;
               else if (!w_is_ext) w_state_next = StIdle;
            end
            StPreF0: begin
               if (w_is_ext)      w_state_next = StPreE0;
               else if (!w_is_brk) w_state_next = StIdle;
            end
            StPreE0F0: w_state_next = StIdle;
            default:   w_state_next = StIdle;
         endcase
      end else if (w_timeout) begin
         w_state_next = StIdle;
      end
   end

   // Output logic: event emission, error detection, timeout counter next value
   always_comb begin
      w_emit        = 1'b0;
      w_emit_ext    = 1'b0;
      w_emit_brk    = 1'b0;
      w_err         = w_timeout;
      w_to_cnt_next = r_to_cnt + TO_W'(1);
      if (bus.rx_ready || w_timeout || (r_state == StIdle)) w_to_cnt_next = '0;
      if (bus.rx_ready) begin
         case (r_state)
            StIdle: begin
               w_emit = MAKE_EN && !w_is_ext && !w_is_brk;
            end
            StPreE0: begin
               w_emit     = MAKE_EN && !w_is_ext && !w_is_brk;
               w_emit_ext = 1'b1;
            end
            StPreF0: begin
               w_err      = w_is_ext;
               w_emit     = !w_is_ext && !w_is_brk;
               w_emit_brk = 1'b1;
            end
            StPreE0F0: begin
               w_err      = w_is_ext || w_is_brk;
               w_emit     = !w_is_ext && !w_is_brk;
               w_emit_ext = 1'b1;
               w_emit_brk = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_to_cnt    <= '0;
         r_proto_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_to_cnt    <= w_to_cnt_next;
         r_proto_err <= w_err;
         // Full implies non-empty, so any pop this cycle makes room for the push.
         if (w_emit && w_full && !bus.ev_pop) r_overflow <= 1'b1;
         else if (bus.clr_overflow)           r_overflow <= 1'b0;
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EV_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_emit),
      .i_data  (ps2_pack_event(w_emit_ext, w_emit_brk, bus.rx_data)),
      .i_pop   (bus.ev_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_count)
   );

   assign bus.ev_valid  = !w_empty;
   assign bus.ev_code   = w_head[EV_CODE_MSB:EV_CODE_LSB];
   assign bus.ev_ext    = w_head[EV_EXT_BIT];
   assign bus.ev_break  = w_head[EV_BRK_BIT];
   assign bus.ev_count  = w_count;
   assign bus.overflow  = r_overflow;
   assign bus.proto_err = r_proto_err;

endmodule
